// File: rtl/rv_trace_buffer_pkg.sv
// Shared types for the retirement/memory trace buffer (package rv_trace_pkg).
// RV_TRACE_MEM_EN widens capture to store/load events, up to three pushes per cycle.
package rv_trace_pkg;

`ifdef RV_TRACE_MEM_EN
   localparam int TRC_MAX_PUSH = 3;
`else
   localparam int TRC_MAX_PUSH = 1;
`endif

   localparam int TRC_CNT_W  = $clog2(TRC_MAX_PUSH + 1);
   localparam int TRC_DATA_W = 32;
   localparam int TRC_ADDR_W = 9;
   localparam int TRC_SEQ_W  = 16;

   typedef enum logic [1:0] {
      TRC_REG   = 2'd0,
      TRC_STORE = 2'd1,
      TRC_LOAD  = 2'd2
   } trace_kind_e;

   typedef struct packed {
      trace_kind_e             kind;
      logic [TRC_ADDR_W-1:0]   tag;
      logic [TRC_DATA_W-1:0]   data;
      logic [TRC_SEQ_W-1:0]    seq;
   } trace_entry_t;

   // Saturating add of a per-cycle drop count onto the running drop counter.
   function automatic logic [TRC_SEQ_W-1:0] sat_add_cnt(input logic [TRC_SEQ_W-1:0] base,
                                                       input logic [TRC_CNT_W-1:0] inc);
      logic [TRC_SEQ_W:0] sum;
      sum = {1'b0, base} + (TRC_SEQ_W + 1)'(inc);
      return sum[TRC_SEQ_W] ? {TRC_SEQ_W{1'b1}} : sum[TRC_SEQ_W-1:0];
   endfunction

endpackage

// File: rtl/rv_trace_buffer_if.sv
// Trace drain handshake: the buffer is master (valid + payload), the sink is slave (ready).
interface rv_trace_buffer_if #(
   parameter int ADDR_W = rv_trace_pkg::TRC_ADDR_W,
   parameter int DATA_W = rv_trace_pkg::TRC_DATA_W,
   parameter int SEQ_W  = rv_trace_pkg::TRC_SEQ_W
);
   logic                      trc_valid;
   logic                      trc_ready;
   rv_trace_pkg::trace_kind_e trc_kind;
   logic [ADDR_W-1:0]         trc_tag;
   logic [DATA_W-1:0]         trc_data;
   logic [SEQ_W-1:0]          trc_seq;

   modport master (
      output trc_valid, trc_kind, trc_tag, trc_data, trc_seq,
      input  trc_ready
   );

   modport slave (
      input  trc_valid, trc_kind, trc_tag, trc_data, trc_seq,
      output trc_ready
   );
endinterface

// File: rtl/rv_trace_buffer_trc_fifo.sv
// Multi-push / single-pop synchronous FIFO of trace entries. The caller guarantees
// push_cnt never exceeds the free slots (including a same-cycle pop).
module trc_fifo
   import rv_trace_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [TRC_CNT_W-1:0] push_cnt,
   input  trace_entry_t         push_data [TRC_MAX_PUSH],
   input  logic                 pop,
   output trace_entry_t         head,
   output logic [LVL_W-1:0]     level,
   output logic                 empty
);

   trace_entry_t     mem_q [DEPTH];
   trace_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q,  level_d;
   logic             pop_eff_s;

   // Next-state: write the first push_cnt entries at consecutive slots, advance pointers.
   always_comb begin
      mem_d     = mem_q;
      pop_eff_s = pop && (level_q != {LVL_W{1'b0}});
      for (int k = 0; k < TRC_MAX_PUSH; k++) begin
         mem_d[wr_ptr_q + PTR_W'(k)] = (TRC_CNT_W'(k) < push_cnt) ? push_data[k]
                                                                   : mem_d[wr_ptr_q + PTR_W'(k)];
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff_s);
      level_d  = level_q + LVL_W'(push_cnt) - LVL_W'(pop_eff_s);
   end

   // Storage and pointer registers; reset discards every buffered entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         level_q  <= {LVL_W{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign level = level_q;
   assign empty = (level_q == {LVL_W{1'b0}});

endmodule

// File: rtl/rv_trace_buffer.sv
// Retirement/memory trace capture: detects events, stamps sequence numbers, buffers and drains them.
// Define RV_TRACE_MEM_EN to also capture store/load events from the data-memory port.
module rv_trace_buffer
   import rv_trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int DATA_W = TRC_DATA_W,
   parameter int ADDR_W = TRC_ADDR_W,
   parameter int SEQ_W  = TRC_SEQ_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reg_write_sig,
   input  logic [4:0]            reg_num,
   input  logic [DATA_W-1:0]     reg_data,
   input  logic                  wr,
   input  logic                  rd,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W-1:0]     rd_data,
   input  logic                  clr_ovf,
   rv_trace_buffer_if.master     trc,
   output logic [$clog2(DEPTH):0] level,
   output logic                  overflow,
   output logic [SEQ_W-1:0]      drop_cnt
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [TRC_MAX_PUSH-1:0] ev_valid_s;
   trace_entry_t            src_s       [TRC_MAX_PUSH];
   logic [TRC_CNT_W-1:0]    rank_s      [TRC_MAX_PUSH];
   trace_entry_t            push_data_s [TRC_MAX_PUSH];
   trace_entry_t            stamp_s;
   trace_entry_t            head_s;
   logic [TRC_CNT_W-1:0]    cnt_s;
   logic [TRC_CNT_W-1:0]    n_ev_s, n_acc_s, n_drop_s;
   logic [LVL_W-1:0]        level_s, free_s;
   logic                    empty_s, pop_s;

   logic [TRC_SEQ_W-1:0]    seq_q, seq_d;
   logic                    overflow_q, overflow_d;
   logic [TRC_SEQ_W-1:0]    drop_cnt_q, drop_cnt_d;

   // Event detection, listed in push order: writeback belongs to the older instruction.
   always_comb begin
      ev_valid_s    = {TRC_MAX_PUSH{1'b0}};
      src_s         = '{default: '0};
      ev_valid_s[0] = reg_write_sig && (reg_num != 5'd0);
      src_s[0].kind = TRC_REG;
      src_s[0].tag  = TRC_ADDR_W'(reg_num);
      src_s[0].data = reg_data;
`ifdef RV_TRACE_MEM_EN
      ev_valid_s[1] = wr;
      src_s[1].kind = TRC_STORE;
      src_s[1].tag  = addr;
      src_s[1].data = wr_data;
      ev_valid_s[2] = rd;
      src_s[2].kind = TRC_LOAD;
      src_s[2].tag  = addr;
      src_s[2].data = rd_data;
`endif
   end

`ifndef RV_TRACE_MEM_EN
   logic unused_mem_s;
   assign unused_mem_s = ^{wr, rd, addr, wr_data, rd_data};
`endif

   // Rank each event among this cycle's events, stamp its sequence number and compact.
   always_comb begin
      cnt_s = {TRC_CNT_W{1'b0}};
      for (int i = 0; i < TRC_MAX_PUSH; i++) begin
         rank_s[i] = cnt_s;
         cnt_s     = cnt_s + TRC_CNT_W'(ev_valid_s[i]);
      end
      n_ev_s      = cnt_s;
      push_data_s = '{default: '0};
      stamp_s     = '0;
      for (int k = 0; k < TRC_MAX_PUSH; k++) begin
         for (int i = 0; i < TRC_MAX_PUSH; i++) begin
            stamp_s        = src_s[i];
            stamp_s.seq    = seq_q + TRC_SEQ_W'(rank_s[i]);
            push_data_s[k] = (ev_valid_s[i] && (rank_s[i] == TRC_CNT_W'(k))) ? stamp_s
                                                                              : push_data_s[k];
         end
      end
   end

   // Acceptance against free slots; surplus events are dropped, never stalled.
   always_comb begin
      pop_s  = !empty_s && trc.trc_ready;
      free_s = LVL_W'(DEPTH) - level_s + LVL_W'(pop_s);
      if (LVL_W'(n_ev_s) > free_s) begin
         n_acc_s = free_s[TRC_CNT_W-1:0];
      end else begin
         n_acc_s = n_ev_s;
      end
      n_drop_s = n_ev_s - n_acc_s;
      seq_d    = seq_q + TRC_SEQ_W'(n_ev_s);
      // A drop in the same cycle as clr_ovf wins: the count restarts at the new drops.
      if (n_drop_s != {TRC_CNT_W{1'b0}}) begin
         overflow_d = 1'b1;
         drop_cnt_d = sat_add_cnt(clr_ovf ? {TRC_SEQ_W{1'b0}} : drop_cnt_q, n_drop_s);
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
         drop_cnt_d = {TRC_SEQ_W{1'b0}};
      end else begin
         overflow_d = overflow_q;
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Sequence counter and overflow accounting registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seq_q      <= {TRC_SEQ_W{1'b0}};
         overflow_q <= 1'b0;
         drop_cnt_q <= {TRC_SEQ_W{1'b0}};
      end else begin
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   trc_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_cnt  (n_acc_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .head      (head_s),
      .level     (level_s),
      .empty     (empty_s)
   );

   assign trc.trc_valid = !empty_s;
   assign trc.trc_kind  = head_s.kind;
   assign trc.trc_tag   = head_s.tag;
   assign trc.trc_data  = head_s.data;
   assign trc.trc_seq   = head_s.seq;
   assign level         = level_s;
   assign overflow      = overflow_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_rv_trace_buffer.sv
// Self-checking bench for rv_trace_buffer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model. Honours RV_TRACE_MEM_EN.
module tb_rv_trace_buffer;
   import rv_trace_pkg::*;

   localparam int DEPTH  = 16;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int SEQ_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              reg_write_sig;
   logic [4:0]        reg_num;
   logic [DATA_W-1:0] reg_data;
   logic              wr, rd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data, rd_data;
   logic              clr_ovf;
   logic [4:0]        level;
   logic              overflow;
   logic [SEQ_W-1:0]  drop_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          kind;
      int          tag;
      logic [31:0] data;
      logic [15:0] seq;
   } m_ent_t;

   m_ent_t      mq[$];
   logic [15:0] m_seq;
   bit          m_ovf;
   int          m_drop;

   always #5 clk = ~clk;

   rv_trace_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEQ_W(SEQ_W)) trc_if ();

   rv_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEQ_W(SEQ_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .reg_write_sig (reg_write_sig),
      .reg_num       (reg_num),
      .reg_data      (reg_data),
      .wr            (wr),
      .rd            (rd),
      .addr          (addr),
      .wr_data       (wr_data),
      .rd_data       (rd_data),
      .clr_ovf       (clr_ovf),
      .trc           (trc_if),
      .level         (level),
      .overflow      (overflow),
      .drop_cnt      (drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_seq  = 16'd0;
      m_ovf  = 1'b0;
      m_drop = 0;
   endfunction

   // Reference behaviour for one clock edge, using the inputs present at that edge.
   function automatic void model_edge();
      m_ent_t ev[$];
      m_ent_t e;
      int     dropped = 0;
      if (mq.size() > 0 && trc_if.trc_ready) void'(mq.pop_front());
      if (reg_write_sig && reg_num != 5'd0) begin
         e = '{0, int'(reg_num), reg_data, 16'd0};
         ev.push_back(e);
      end
`ifdef RV_TRACE_MEM_EN
      if (wr) begin
         e = '{1, int'(addr), wr_data, 16'd0};
         ev.push_back(e);
      end
      if (rd) begin
         e = '{2, int'(addr), rd_data, 16'd0};
         ev.push_back(e);
      end
`endif
      foreach (ev[i]) begin
         e     = ev[i];
         e.seq = m_seq;
         m_seq = m_seq + 16'd1;
         if (mq.size() < DEPTH) mq.push_back(e);
         else dropped++;
      end
      if (dropped > 0) begin
         m_ovf  = 1'b1;
         m_drop = (clr_ovf ? 0 : m_drop) + dropped;
         if (m_drop > 65535) m_drop = 65535;
      end else if (clr_ovf) begin
         m_ovf  = 1'b0;
         m_drop = 0;
      end
   endfunction

   task automatic compare_all();
      chk("valid", trc_if.trc_valid, (mq.size() > 0));
      chk("level", level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (mq.size() > 0) begin
         chk("kind", trc_if.trc_kind, mq[0].kind);
         chk("tag", trc_if.trc_tag, mq[0].tag);
         chk("data", trc_if.trc_data, mq[0].data);
         chk("seq", trc_if.trc_seq, mq[0].seq);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      compare_all();
   endtask

   task automatic idle_inputs(input bit rdy);
      reg_write_sig     = 1'b0;
      reg_num           = 5'd0;
      reg_data          = 32'd0;
      wr                = 1'b0;
      rd                = 1'b0;
      addr              = 9'd0;
      wr_data           = 32'd0;
      rd_data           = 32'd0;
      clr_ovf           = 1'b0;
      trc_if.trc_ready  = rdy;
   endtask

   task automatic reg_ev(input logic [4:0] n, input logic [31:0] d, input bit rdy);
      idle_inputs(rdy);
      reg_write_sig = 1'b1;
      reg_num       = n;
      reg_data      = d;
   endtask

   task automatic apply_reset();
      idle_inputs(1'b0);
      reset = 1'b1;
      #2;
      model_reset();
      chk("rst_level", level, 5'd0);
      chk("rst_valid", trc_if.trc_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int pct;
      idle_inputs(1'b0);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_valid0", trc_if.trc_valid, 1'b0);
      chk("rst_kind", trc_if.trc_kind, 2'd0);
      chk("rst_tag", trc_if.trc_tag, 9'd0);
      chk("rst_data", trc_if.trc_data, 32'd0);
      chk("rst_seq", trc_if.trc_seq, 16'd0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_drop", drop_cnt, 16'd0);
      reset = 1'b0;

      // Single writeback x5 appears one cycle later with seq 0.
      reg_ev(5'd5, 32'h1234_5678, 1'b1);
      step();
      chk("x5_data", trc_if.trc_data, 32'h1234_5678);
      chk("x5_tag", trc_if.trc_tag, 9'd5);
      chk("x5_seq", trc_if.trc_seq, 16'd0);
      idle_inputs(1'b1);
      step();

      // x0 writes are filtered and consume no sequence number.
      reg_ev(5'd0, 32'hdead_beef, 1'b1);
      step();
      chk("x0_valid", trc_if.trc_valid, 1'b0);
      reg_ev(5'd7, 32'h0000_00a7, 1'b1);
      step();
      chk("x0_seq", trc_if.trc_seq, 16'd1);
      idle_inputs(1'b1);
      step();

      // Seventeen events into a stalled sink: one drop.
      apply_reset();
      for (int i = 0; i < 17; i++) begin
         reg_ev(5'(i % 31 + 1), 32'(i * 3 + 100), 1'b0);
         step();
      end
      chk("full_level", level, 5'd16);
      chk("full_ovf", overflow, 1'b1);
      chk("full_drop", drop_cnt, 16'd1);
      chk("full_head_seq", trc_if.trc_seq, 16'd0);

      // Full FIFO: a push in the same cycle as a pop is accepted.
      reg_ev(5'd9, 32'h0bad_cafe, 1'b1);
      step();
      chk("fullpop_level", level, 5'd16);
      chk("fullpop_drop", drop_cnt, 16'd1);
      for (int i = 0; i < 18; i++) begin
         idle_inputs(1'b1);
         step();
      end

      // Clear overflow.
      idle_inputs(1'b1);
      clr_ovf = 1'b1;
      step();
      chk("clr_ovf", overflow, 1'b0);

`ifdef RV_TRACE_MEM_EN
      // One slot free: the writeback is kept, the same-cycle store is dropped.
      apply_reset();
      for (int i = 0; i < 15; i++) begin
         reg_ev(5'd1, 32'(i), 1'b0);
         step();
      end
      reg_ev(5'd3, 32'h3333_3333, 1'b0);
      wr      = 1'b1;
      addr    = 9'h040;
      wr_data = 32'h4040_4040;
      step();
      chk("mem_level", level, 5'd16);
      chk("mem_drop", drop_cnt, 16'd1);
      for (int i = 0; i < 17; i++) begin
         idle_inputs(1'b1);
         step();
      end
`endif

      // Reset with entries in flight clears immediately; sequencing restarts.
      for (int i = 0; i < 8; i++) begin
         reg_ev(5'd2, 32'(i + 50), 1'b0);
         step();
      end
      chk("pre_rst_level", level, 5'd8);
      apply_reset();
      reg_ev(5'd4, 32'h0000_0444, 1'b0);
      step();
      chk("post_rst_seq", trc_if.trc_seq, 16'd0);

      // Randomized traffic with varying sink throughput.
      for (int blk = 0; blk < 8; blk++) begin
         pct = 10 + blk * 11;
         for (int c = 0; c < 100; c++) begin
            idle_inputs($urandom_range(0, 99) < pct);
            reg_write_sig = ($urandom_range(0, 3) != 0);
            reg_num       = 5'($urandom_range(0, 31));
            reg_data      = $urandom;
            wr            = ($urandom_range(0, 2) == 0);
            rd            = ($urandom_range(0, 2) == 0);
            addr          = 9'($urandom_range(0, 511));
            wr_data       = $urandom;
            rd_data       = $urandom;
            clr_ovf       = ($urandom_range(0, 39) == 0);
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
